// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA mode sequencer: mode codes, FSM state
// encoding and the per-mode timing table.
package vga_timing_pkg;

  localparam int TWIDTH = 12;

  localparam logic [1:0] MODE_640x480  = 2'd0;
  localparam logic [1:0] MODE_800x600  = 2'd1;
  localparam logic [1:0] MODE_1280x720 = 2'd2;
  localparam logic [1:0] MODE_RSVD     = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PENDING = 2'd1,
    ST_APPLY   = 2'd2,
    ST_MUTE    = 2'd3
  } state_t;

  typedef struct packed {
    logic [TWIDTH-1:0] h_fp;
    logic [TWIDTH-1:0] h_sw;
    logic [TWIDTH-1:0] h_bp;
    logic [TWIDTH-1:0] h_act;
    logic [TWIDTH-1:0] v_fp;
    logic [TWIDTH-1:0] v_sw;
    logic [TWIDTH-1:0] v_bp;
    logic [TWIDTH-1:0] v_act;
  } timing_t;

  localparam timing_t TIMING_640x480 = '{
    h_fp: 12'd16,  h_sw: 12'd96,  h_bp: 12'd48,  h_act: 12'd640,
    v_fp: 12'd10,  v_sw: 12'd2,   v_bp: 12'd33,  v_act: 12'd480};

  localparam timing_t TIMING_800x600 = '{
    h_fp: 12'd40,  h_sw: 12'd128, h_bp: 12'd88,  h_act: 12'd800,
    v_fp: 12'd1,   v_sw: 12'd4,   v_bp: 12'd23,  v_act: 12'd600};

  localparam timing_t TIMING_1280x720 = '{
    h_fp: 12'd110, h_sw: 12'd40,  h_bp: 12'd220, h_act: 12'd1280,
    v_fp: 12'd5,   v_sw: 12'd5,   v_bp: 12'd20,  v_act: 12'd720};

  // Timing fields for a mode code; the reserved code returns all zeros.
  function automatic timing_t mode_timing(input logic [1:0] mode);
    timing_t t;
    case (mode)
      MODE_640x480:  t = TIMING_640x480;
      MODE_800x600:  t = TIMING_800x600;
      MODE_1280x720: t = TIMING_1280x720;
      default:       t = '0;
    endcase
    return t;
  endfunction

  function automatic logic mode_valid(input logic [1:0] mode);
    return mode != MODE_RSVD;
  endfunction

endpackage

// File: rtl/vga_mode_rom.sv
// Combinational mode table: maps a 2-bit mode code to its eight timing
// fields and a flag saying whether the code names a real mode.
module vga_mode_rom
  import vga_timing_pkg::*;
(
  input  logic [1:0]        mode,
  output logic [TWIDTH-1:0] h_fp,
  output logic [TWIDTH-1:0] h_sw,
  output logic [TWIDTH-1:0] h_bp,
  output logic [TWIDTH-1:0] h_act,
  output logic [TWIDTH-1:0] v_fp,
  output logic [TWIDTH-1:0] v_sw,
  output logic [TWIDTH-1:0] v_bp,
  output logic [TWIDTH-1:0] v_act,
  output logic              valid
);

  timing_t t;

  assign t     = mode_timing(mode);
  assign h_fp  = t.h_fp;
  assign h_sw  = t.h_sw;
  assign h_bp  = t.h_bp;
  assign h_act = t.h_act;
  assign v_fp  = t.v_fp;
  assign v_sw  = t.v_sw;
  assign v_bp  = t.v_bp;
  assign v_act = t.v_act;
  assign valid = mode_valid(mode);

endmodule

// File: rtl/vga_mode_sequencer.sv
// Holds the active video mode and sequences mode changes: a request waits
// for a frame boundary (or timeout), the generator is held in reset while
// new parameters settle, then video stays muted for a few frames.
module vga_mode_sequencer
  import vga_timing_pkg::*;
#(
  parameter logic [1:0]  RESET_MODE     = 2'd2,
  parameter int unsigned GEN_RST_CYCLES = 16,
  parameter int unsigned MUTE_FRAMES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic              clk_pixel,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [1:0]        req_mode,
  output logic              req_ready,
  output logic              req_err,
  output logic              mode_done,
  output logic [1:0]        cur_mode,
  input  logic              frame_start,
  output logic              gen_run,
  output logic              video_mute,
  output logic [TWIDTH-1:0] h_fp,
  output logic [TWIDTH-1:0] h_sw,
  output logic [TWIDTH-1:0] h_bp,
  output logic [TWIDTH-1:0] h_act,
  output logic [TWIDTH-1:0] v_fp,
  output logic [TWIDTH-1:0] v_sw,
  output logic [TWIDTH-1:0] v_bp,
  output logic [TWIDTH-1:0] v_act
);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]  cur_mode_q, cur_mode_d;
  logic [1:0]  pend_mode_q, pend_mode_d;
  timing_t     timing_q, timing_d;
  logic        gen_run_q, gen_run_d;
  logic        video_mute_q, video_mute_d;
  logic        req_ready_q, req_ready_d;
  logic        req_err_q, req_err_d;
  logic        mode_done_q, mode_done_d;

  // In RUN the table validates the incoming request; elsewhere it supplies
  // the timing of the pending mode for the load on entry to APPLY.
  logic [1:0] rom_mode;
  timing_t    rom_timing;
  logic       rom_valid;

  assign rom_mode = (state_q == ST_RUN) ? req_mode : pend_mode_q;

  vga_mode_rom u_rom (
    .mode  (rom_mode),
    .h_fp  (rom_timing.h_fp),
    .h_sw  (rom_timing.h_sw),
    .h_bp  (rom_timing.h_bp),
    .h_act (rom_timing.h_act),
    .v_fp  (rom_timing.v_fp),
    .v_sw  (rom_timing.v_sw),
    .v_bp  (rom_timing.v_bp),
    .v_act (rom_timing.v_act),
    .valid (rom_valid)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;

  // Next-state and next-output logic; the single counter clears on every state entry.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_mode_d   = cur_mode_q;
    pend_mode_d  = pend_mode_q;
    timing_d     = timing_q;
    gen_run_d    = gen_run_q;
    video_mute_d = video_mute_q;
    req_ready_d  = req_ready_q;
    req_err_d    = 1'b0;
    mode_done_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (req_valid && req_ready_q) begin
          if (!rom_valid) begin
            req_err_d = 1'b1;
          end else if (req_mode == cur_mode_q) begin
            mode_done_d = 1'b1;
          end else begin
            pend_mode_d = req_mode;
            req_ready_d = 1'b0;
            cnt_d       = '0;
            state_d     = ST_PENDING;
          end
        end
      end
      ST_PENDING: begin
        if (frame_start || (cnt_q == TIMEOUT_CYCLES - 1)) begin
          cur_mode_d   = pend_mode_q;
          timing_d     = rom_timing;
          gen_run_d    = 1'b0;
          video_mute_d = 1'b1;
          cnt_d        = '0;
          state_d      = ST_APPLY;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_APPLY: begin
        if (cnt_q == GEN_RST_CYCLES - 1) begin
          gen_run_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_MUTE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_MUTE: begin
        if (frame_start) begin
          if (cnt_q == MUTE_FRAMES - 1) begin
            video_mute_d = 1'b0;
            mode_done_d  = 1'b1;
            req_ready_d  = 1'b1;
            cnt_d        = '0;
            state_d      = ST_RUN;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = ST_APPLY;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs; reset lands in APPLY with the reset mode loaded.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_APPLY;
      cnt_q        <= '0;
      cur_mode_q   <= RESET_MODE;
      pend_mode_q  <= RESET_MODE;
      timing_q     <= mode_timing(RESET_MODE);
      gen_run_q    <= 1'b0;
      video_mute_q <= 1'b1;
      req_ready_q  <= 1'b0;
      req_err_q    <= 1'b0;
      mode_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_mode_q   <= cur_mode_d;
      pend_mode_q  <= pend_mode_d;
      timing_q     <= timing_d;
      gen_run_q    <= gen_run_d;
      video_mute_q <= video_mute_d;
      req_ready_q  <= req_ready_d;
      req_err_q    <= req_err_d;
      mode_done_q  <= mode_done_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign req_err    = req_err_q;
  assign mode_done  = mode_done_q;
  assign cur_mode   = cur_mode_q;
  assign gen_run    = gen_run_q;
  assign video_mute = video_mute_q;
  assign h_fp       = timing_q.h_fp;
  assign h_sw       = timing_q.h_sw;
  assign h_bp       = timing_q.h_bp;
  assign h_act      = timing_q.h_act;
  assign v_fp       = timing_q.v_fp;
  assign v_sw       = timing_q.v_sw;
  assign v_bp       = timing_q.v_bp;
  assign v_act      = timing_q.v_act;

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Directed bench for vga_mode_sequencer: reset bring-up, a frame-aligned
// switch, single-cycle RUN behaviour from a vector table, timeout-forced
// apply, coincident frame/timeout, and asynchronous reset mid-sequence.
module tb_vga_mode_sequencer;
  import vga_timing_pkg::*;

  logic              clk_pixel = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic [1:0]        req_mode = 2'd0;
  logic              frame_start = 1'b0;
  logic              req_ready, req_err, mode_done, gen_run, video_mute;
  logic [1:0]        cur_mode;
  logic [TWIDTH-1:0] h_fp, h_sw, h_bp, h_act, v_fp, v_sw, v_bp, v_act;

  int check_count = 0;
  int pass_count  = 0;

  vga_mode_sequencer #(
    .RESET_MODE     (2'd2),
    .GEN_RST_CYCLES (16),
    .MUTE_FRAMES    (2),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk_pixel   (clk_pixel),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_mode    (req_mode),
    .req_ready   (req_ready),
    .req_err     (req_err),
    .mode_done   (mode_done),
    .cur_mode    (cur_mode),
    .frame_start (frame_start),
    .gen_run     (gen_run),
    .video_mute  (video_mute),
    .h_fp        (h_fp),
    .h_sw        (h_sw),
    .h_bp        (h_bp),
    .h_act       (h_act),
    .v_fp        (v_fp),
    .v_sw        (v_sw),
    .v_bp        (v_bp),
    .v_act       (v_act)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    string      name;
    logic       valid;
    logic [1:0] mode;
    logic       frame;
    logic       exp_ready;
    logic       exp_err;
    logic       exp_done;
    logic [1:0] exp_mode;
    logic       exp_gen_run;
    logic       exp_mute;
    int         exp_h_act;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
  endtask

  // Drive one cycle of inputs, let one edge pass, then return inputs to idle.
  task automatic applyStimulus(input logic v, input logic [1:0] m, input logic f);
    req_valid   = v;
    req_mode    = m;
    frame_start = f;
    step();
    req_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic waitGenRun(input logic level, input int limit, output int n);
    n = 0;
    while (gen_run != level && n < limit) begin
      step();
      n++;
    end
  endtask

  // Reset, then walk the bring-up path back to RUN in mode 2.
  task automatic resetAndRecover();
    int n;
    rst_n = 1'b0;
    step();
    checkOutput("rst_cur_mode", cur_mode, 2);
    checkOutput("rst_h_act", h_act, 1280);
    checkOutput("rst_v_act", v_act, 720);
    checkOutput("rst_gen_run", gen_run, 0);
    checkOutput("rst_mute", video_mute, 1);
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_done", mode_done, 0);
    rst_n = 1'b1;
    waitGenRun(1'b1, 100, n);
    checkOutput("rst_gen_hold_cycles", n, 16);
    checkOutput("rst_mute_in_mute", video_mute, 1);
    applyStimulus(1'b0, 2'd0, 1'b1);
    checkOutput("rst_mute_after_f1", video_mute, 1);
    checkOutput("rst_done_after_f1", mode_done, 0);
    applyStimulus(1'b0, 2'd0, 1'b1);
    checkOutput("rst_mute_after_f2", video_mute, 0);
    checkOutput("rst_done_after_f2", mode_done, 1);
    checkOutput("rst_ready_after_f2", req_ready, 1);
    step();
    checkOutput("rst_done_one_cycle", mode_done, 0);
  endtask

  initial begin
    int n;
    int bad;
    int done_cnt;

    vecs[0] = '{"run_idle",        1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 640};
    vecs[1] = '{"run_invalid",     1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 640};
    vecs[2] = '{"run_err_clears",  1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 640};
    vecs[3] = '{"run_same_mode",   1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 640};
    vecs[4] = '{"run_frame_only",  1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 640};
    vecs[5] = '{"run_inv_w_frame", 1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 640};
    vecs[6] = '{"run_same_again",  1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 640};
    vecs[7] = '{"run_same_b2b",    1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 640};

    resetAndRecover();

    // Switch to mode 0, frame boundary arrives 50 cycles after acceptance.
    applyStimulus(1'b1, 2'd0, 1'b0);
    checkOutput("sw0_accept_ready", req_ready, 0);
    checkOutput("sw0_accept_h_act", h_act, 1280);
    bad = 0;
    for (int i = 0; i < 49; i++) begin
      step();
      if (h_act != 12'd1280 || gen_run != 1'b1 || video_mute != 1'b0 || cur_mode != 2'd2) bad++;
    end
    checkOutput("sw0_pending_stable", bad, 0);
    applyStimulus(1'b0, 2'd0, 1'b1);
    checkOutput("sw0_h_act", h_act, 640);
    checkOutput("sw0_v_sw", v_sw, 2);
    checkOutput("sw0_h_sw", h_sw, 96);
    checkOutput("sw0_cur_mode", cur_mode, 0);
    checkOutput("sw0_gen_run", gen_run, 0);
    checkOutput("sw0_mute", video_mute, 1);
    waitGenRun(1'b1, 100, n);
    checkOutput("sw0_gen_hold_cycles", n, 16);
    done_cnt = 0;
    applyStimulus(1'b0, 2'd0, 1'b1);
    done_cnt += int'(mode_done);
    checkOutput("sw0_mute_after_f1", video_mute, 1);
    applyStimulus(1'b0, 2'd0, 1'b1);
    done_cnt += int'(mode_done);
    checkOutput("sw0_mute_after_f2", video_mute, 0);
    checkOutput("sw0_ready_after_f2", req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      done_cnt += int'(mode_done);
    end
    checkOutput("sw0_done_pulses", done_cnt, 1);

    // Single-cycle RUN behaviour in mode 0.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].mode, vecs[i].frame);
      checkOutput({vecs[i].name, "_ready"}, req_ready, vecs[i].exp_ready);
      checkOutput({vecs[i].name, "_err"}, req_err, vecs[i].exp_err);
      checkOutput({vecs[i].name, "_done"}, mode_done, vecs[i].exp_done);
      checkOutput({vecs[i].name, "_mode"}, cur_mode, vecs[i].exp_mode);
      checkOutput({vecs[i].name, "_gen_run"}, gen_run, vecs[i].exp_gen_run);
      checkOutput({vecs[i].name, "_mute"}, video_mute, vecs[i].exp_mute);
      checkOutput({vecs[i].name, "_h_act"}, h_act, vecs[i].exp_h_act);
    end

    // Mode 1 request with no frame_start: timeout forces the apply.
    applyStimulus(1'b1, 2'd1, 1'b0);
    checkOutput("tmo_accept_ready", req_ready, 0);
    waitGenRun(1'b0, 300, n);
    checkOutput("tmo_latency", n, 100);
    checkOutput("tmo_h_act", h_act, 800);
    checkOutput("tmo_v_act", v_act, 600);
    checkOutput("tmo_h_fp", h_fp, 40);
    checkOutput("tmo_v_fp", v_fp, 1);
    checkOutput("tmo_v_bp", v_bp, 23);
    checkOutput("tmo_cur_mode", cur_mode, 1);
    waitGenRun(1'b1, 100, n);
    checkOutput("tmo_gen_hold_cycles", n, 16);
    applyStimulus(1'b0, 2'd0, 1'b1);
    checkOutput("tmo_mute_in_mute", video_mute, 1);

    // Asynchronous reset in MUTE, between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_cur_mode", cur_mode, 2);
    checkOutput("arst_gen_run", gen_run, 0);
    checkOutput("arst_mute", video_mute, 1);
    checkOutput("arst_h_act", h_act, 1280);
    checkOutput("arst_ready", req_ready, 0);

    resetAndRecover();

    // frame_start lands on the timeout cycle; frame_start also held through APPLY.
    applyStimulus(1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 99; i++) step();
    checkOutput("coin_still_pending", gen_run, 1);
    applyStimulus(1'b0, 2'd0, 1'b1);
    checkOutput("coin_gen_run", gen_run, 0);
    checkOutput("coin_h_act", h_act, 640);
    frame_start = 1'b1;
    waitGenRun(1'b1, 100, n);
    frame_start = 1'b0;
    checkOutput("coin_gen_hold_cycles", n, 16);
    checkOutput("coin_mute_in_mute", video_mute, 1);
    applyStimulus(1'b0, 2'd0, 1'b1);
    checkOutput("coin_mute_after_f1", video_mute, 1);
    applyStimulus(1'b0, 2'd0, 1'b1);
    checkOutput("coin_done_after_f2", mode_done, 1);
    checkOutput("coin_mute_after_f2", video_mute, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
